// File: rtl/adder2_accum_stage.sv
// adder2_accum_stage: reduces three adder1 partial sums per beat and accumulates ACC_LEN beats per output.
// Define ADDER2_SAT_EN for saturating accumulation and the extra sat_flag output.
module adder2_accum_stage #(
    parameter int IN_W    = 20,
    parameter int OUT_W   = 24,
    parameter int ACC_LEN = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic signed [IN_W-1:0] adder1_result [2:0],
    output logic                   stall,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OUT_W-1:0]       out_psum,
    output logic                   busy
`ifdef ADDER2_SAT_EN
    ,
    output logic                   sat_flag
`endif
);
    localparam int AW = OUT_W + 2;
    typedef enum logic {ACC, HOLD} state_t;
    state_t state, state_nx;
    logic [7:0] beat_cnt, beat_cnt_nx;
    logic signed [AW-1:0] sum3, acc, acc_nx, acc_sum;
    logic [OUT_W-1:0] psum_nx, fitted;
    logic accept, first, last;
    assign sum3      = AW'(adder1_result[0]) + AW'(adder1_result[1]) + AW'(adder1_result[2]);
    assign out_valid = state == HOLD;
    assign stall     = out_valid & ~out_ready;
    assign accept    = in_valid & ~stall;
    assign first     = beat_cnt == 8'd0;
    assign last      = beat_cnt == 8'(ACC_LEN - 1);
    assign busy      = !first || out_valid;
    assign acc_sum   = first ? sum3 : acc + sum3;
`ifdef ADDER2_SAT_EN
    localparam logic signed [AW-1:0] SMAX = {3'b000, {(OUT_W-1){1'b1}}};
    localparam logic signed [AW-1:0] SMIN = {3'b111, {(OUT_W-1){1'b0}}};
    logic clip, grp_sat, grp_sat_nx, sat_nx;
    assign clip   = acc_sum > SMAX || acc_sum < SMIN;
    assign fitted = acc_sum > SMAX ? SMAX[OUT_W-1:0] :
                    acc_sum < SMIN ? SMIN[OUT_W-1:0] : acc_sum[OUT_W-1:0];
    // group clamp history restarts whenever a beat opens a new group
    assign grp_sat_nx = accept && !last ? (!first && grp_sat) || clip : grp_sat;
    assign sat_nx     = accept && last ? (!first && grp_sat) || clip :
                        out_valid && out_ready ? 1'b0 : sat_flag;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grp_sat  <= 1'b0;
            sat_flag <= 1'b0;
        end else begin
            grp_sat  <= grp_sat_nx;
            sat_flag <= sat_nx;
        end
    end
`else
    logic unused_hi;
    assign fitted    = acc_sum[OUT_W-1:0];
    assign unused_hi = ^acc_sum[AW-1:OUT_W];
`endif
    always_comb begin
        state_nx    = state;
        beat_cnt_nx = beat_cnt;
        acc_nx      = acc;
        psum_nx     = out_psum;
        if (accept && last) begin
            state_nx    = HOLD;
            beat_cnt_nx = 8'd0;
            psum_nx     = fitted;
        end else if (accept) begin
            state_nx    = ACC;
            beat_cnt_nx = beat_cnt + 8'd1;
            acc_nx      = AW'(signed'(fitted));
        end else if (out_valid && out_ready) begin
            state_nx = ACC;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ACC;
            beat_cnt <= 8'd0;
            acc      <= '0;
            out_psum <= '0;
        end else begin
            state    <= state_nx;
            beat_cnt <= beat_cnt_nx;
            acc      <= acc_nx;
            out_psum <= psum_nx;
        end
    end
endmodule
